pipeline_register_chain: RTL

PIPELINE_REGISTER_CHAIN -- requirements
Module: pipeline_register_chain

---
 rtl/pipeline_register_chain.sv | 68 ++++++
 1 files changed

// File: rtl/pipeline_register_chain.sv
// pipeline_register_chain: DEPTH-stage rd/result/we/valid chain with stall bubbles, hold, flush; optional bubble counter via PIPEREG_BUBBLE_COUNT_EN
module pipeline_register_chain #(
  parameter int DATA_W = 32,
  parameter int RD_W = 4,
  parameter int DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  invalid_in,
  input  logic [RD_W-1:0]       rd_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic                  regfile_we_in,
  output logic [RD_W-1:0]       rd_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic                  regfile_we_out,
  output logic                  valid_out,
  output logic [DEPTH*RD_W-1:0] tap_rd,
  output logic [DEPTH-1:0]      tap_we,
  output logic [31:0]           bubble_count
);
  logic [RD_W-1:0]   rd_q  [DEPTH];
  logic [DATA_W-1:0] alu_q [DEPTH];
  logic [DEPTH-1:0]  we_q, valid_q;
  // stage registers: flush clears valids, hold freezes, stall squashes stage 0 to a bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= '0;
        alu_q[k] <= '0;
      end
      we_q <= '0;
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (!hold) begin
      rd_q[0] <= stall ? rd_q[0] : rd_in;
      alu_q[0] <= stall ? alu_q[0] : alu_result_in;
      we_q[0] <= stall ? we_q[0] : regfile_we_in;
      valid_q[0] <= !stall && !invalid_in;
      for (int k = 1; k < DEPTH; k++) begin
        rd_q[k] <= rd_q[k-1];
        alu_q[k] <= alu_q[k-1];
        we_q[k] <= we_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    assign tap_rd[k*RD_W +: RD_W] = rd_q[k];
  end
  assign tap_we = we_q & valid_q;
  assign rd_out = rd_q[DEPTH-1];
  assign alu_result_out = alu_q[DEPTH-1];
  assign regfile_we_out = tap_we[DEPTH-1];
  assign valid_out = valid_q[DEPTH-1];
`ifdef PIPEREG_BUBBLE_COUNT_EN
  logic [31:0] bubble_cnt;
  // saturating count of bubbles entering stage 0
  always_ff @(posedge clk or posedge rst)
    if (rst) bubble_cnt <= '0;
    else if (!flush && !hold && (stall || invalid_in) && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
  assign bubble_count = bubble_cnt;
`else
  assign bubble_count = '0;
`endif
endmodule
